button_conditioner: RTL and testbench

Conditions the raw push buttons (BTNL reset, BTNU confirm, BTND display mode) before they reach the calculator's input handling and display control. Each button is synchronised to `clk` and debounced. It produces a clean level, single-cycle press and release pulses, and a single-cycle long-press pulse. Downstream logic consumes only these pulses and levels, never raw pad signals.

---
 rtl/calc_pkg.sv | 19 +
 rtl/debounce_channel.sv | 133 +++++++++++++
 rtl/button_conditioner.sv | 33 +++
 tb/tb_button_conditioner.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator types, button indices and timing defaults
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } btn_state_t;

  localparam int BTN_RESET   = 0;
  localparam int BTN_CONFIRM = 1;
  localparam int BTN_MODE    = 2;

  // 10 ms debounce and 1 s long press at 100 MHz
  localparam int DEBOUNCE_CYCLES   = 1_000_000;
  localparam int LONG_PRESS_CYCLES = 100_000_000;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: synchroniser, debounce FSM, hold timer
module debounce_channel
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = calc_pkg::DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = calc_pkg::LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic [1:0]        sync_q;
  logic              s;
  btn_state_t        state_q, state_d;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              fired_q, fired_d;
  logic              level_d, press_d, release_d, long_d;

  assign s = sync_q[1];

  // two-flop synchroniser for the asynchronous pad
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
    end
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      deb_q       <= '0;
      hold_q      <= '0;
      fired_q     <= 1'b0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_q       <= deb_d;
      hold_q      <= hold_d;
      fired_q     <= fired_d;
      btn_level   <= level_d;
      btn_press   <= press_d;
      btn_release <= release_d;
      btn_long    <= long_d;
    end
  end

  // next state: debounce both edges; hold timer runs while pressed or releasing
  always_comb begin
    state_d   = state_q;
    deb_d     = deb_q;
    hold_d    = hold_q;
    fired_d   = fired_q;
    level_d   = btn_level;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = ARMING;
          deb_d   = '0;
        end
      end
      ARMING: begin
        if (!s) begin
          state_d = IDLE;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = HELD;
          deb_d   = '0;
          press_d = 1'b1;
          level_d = 1'b1;
          hold_d  = '0;
          fired_d = 1'b0;
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end
      HELD: begin
        if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HOLD_W'(1);
        end
        if (hold_q == HOLD_LAST && !fired_q) begin
          long_d  = 1'b1;
          fired_d = 1'b1;
        end
        if (!s) begin
          state_d = RELEASING;
          deb_d   = '0;
        end
      end
      RELEASING: begin
        if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HOLD_W'(1);
        end
        if (s) begin
          // glitch: resume the hold without touching the long-press state
          state_d = HELD;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d   = IDLE;
          deb_d     = '0;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        deb_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced levels and press/release/long pulses for all buttons
module button_conditioner
  import calc_pkg::*;
#(
  parameter int NUM_BTN           = 3,
  parameter int DEBOUNCE_CYCLES   = calc_pkg::DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = calc_pkg::LONG_PRESS_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .btn_raw    (btn_raw[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i]),
      .btn_long   (btn_long[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner
module tb_button_conditioner;

  localparam int N   = 3;
  localparam int DEB = 4;
  localparam int LNG = 16;

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] lng;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_long;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t exp_q[$];

  logic [N-1:0] m_sync1 = '0, m_sync2 = '0, m_level = '0;
  int           m_run[N];
  int           m_age[N];
  bit           m_fired[N];

  int press_cnt[N], rel_cnt[N], long_cnt[N];
  int press_cyc[N], rel_cyc[N], long_cyc[N];
  int rem[N];

  button_conditioner #(
    .NUM_BTN          (N),
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LNG)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_clear();
    m_sync1 = '0;
    m_sync2 = '0;
    m_level = '0;
    for (int ch = 0; ch < N; ch++) begin
      m_run[ch]   = 0;
      m_age[ch]   = 0;
      m_fired[ch] = 1'b0;
    end
  endtask

  // reference: a level flips once s has disagreed with it for DEB+1 consecutive edges
  always @(posedge clk) begin : model
    exp_t e;
    bit   s;
    e = '0;
    if (reset) begin
      model_clear();
    end else begin
      for (int ch = 0; ch < N; ch++) begin
        s = m_sync2[ch];
        if (m_level[ch]) begin
          if (m_age[ch] < 1000000) m_age[ch]++;
          if (m_run[ch] == 0 && m_age[ch] >= LNG && !m_fired[ch]) begin
            e.lng[ch]   = 1'b1;
            m_fired[ch] = 1'b1;
          end
        end
        if (s != m_level[ch]) begin
          m_run[ch]++;
          if (m_run[ch] == DEB + 1) begin
            m_level[ch] = s;
            m_run[ch]   = 0;
            if (s) begin
              e.press[ch] = 1'b1;
              m_age[ch]   = 0;
              m_fired[ch] = 1'b0;
            end else begin
              e.rel[ch] = 1'b1;
            end
          end
        end else begin
          m_run[ch] = 0;
        end
      end
      e.level = m_level;
      m_sync2 = m_sync1;
      m_sync1 = btn_raw;
    end
    exp_q.push_back(e);
  end

  // asynchronous reset clears outputs straight away
  always @(posedge reset) begin
    model_clear();
    if (exp_q.size() > 0) exp_q[exp_q.size()-1] = '0;
  end

  // monitor: compare every presented output vector against the scoreboard
  always @(negedge clk) begin : monitor
    exp_t e;
    exp_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {btn_level, btn_press, btn_release, btn_long};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs cyc=%0d got lvl/prs/rel/lng=%b/%b/%b/%b expected %b/%b/%b/%b",
                 cyc, a.level, a.press, a.rel, a.lng, e.level, e.press, e.rel, e.lng);
      end
    end
    for (int ch = 0; ch < N; ch++) begin
      if (btn_press[ch] === 1'b1)   begin press_cnt[ch]++; press_cyc[ch] = cyc; end
      if (btn_release[ch] === 1'b1) begin rel_cnt[ch]++;   rel_cyc[ch]   = cyc; end
      if (btn_long[ch] === 1'b1)    begin long_cnt[ch]++;  long_cyc[ch]  = cyc; end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_raw(input logic [N-1:0] v);
    @(posedge clk);
    #3;
    btn_raw = v;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  initial begin : stim
    int c0;
    int p0, p1, p2, r0, l0;
    logic [0:4] bounce;
    reset   = 1'b1;
    btn_raw = '0;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(3);

    // clean press and release on BTNU
    p0 = press_cnt[0]; p1 = press_cnt[1]; p2 = press_cnt[2];
    set_raw(3'b010); c0 = cyc;
    wait_cycles(10);
    check("clean_press_edge", press_cyc[1], c0 + 7);
    check("clean_press_once", press_cnt[1] - p1, 1);
    check("clean_other0", press_cnt[0] - p0, 0);
    check("clean_other2", press_cnt[2] - p2, 0);
    set_raw(3'b000); c0 = cyc;
    wait_cycles(10);
    check("clean_release_edge", rel_cyc[1], c0 + 7);

    // bounce on BTNL
    bounce = 5'b10110;
    p0 = press_cnt[0];
    for (int i = 0; i < 5; i++) set_raw({2'b00, bounce[i]});
    set_raw(3'b001); c0 = cyc;
    wait_cycles(10);
    check("bounce_press_once", press_cnt[0] - p0, 1);
    check("bounce_press_edge", press_cyc[0], c0 + 7);
    set_raw(3'b000);
    wait_cycles(10);

    // long press on BTND
    l0 = long_cnt[2]; r0 = rel_cnt[2];
    set_raw(3'b100); c0 = cyc;
    wait_cycles(39);
    check("long_press_edge", press_cyc[2], c0 + 7);
    check("long_edge", long_cyc[2], c0 + 7 + LNG);
    set_raw(3'b000); c0 = cyc;
    wait_cycles(10);
    check("long_once", long_cnt[2] - l0, 1);
    check("long_release_edge", rel_cyc[2], c0 + 7);
    check("long_release_once", rel_cnt[2] - r0, 1);

    // release glitch during hold on BTNU
    l0 = long_cnt[1]; r0 = rel_cnt[1];
    set_raw(3'b010); c0 = cyc;
    wait_cycles(9);
    set_raw(3'b000);
    wait_cycles(1);
    set_raw(3'b010);
    wait_cycles(20);
    check("glitch_no_release", rel_cnt[1] - r0, 0);
    check("glitch_level", int'(btn_level[1]), 1);
    check("glitch_long_edge", long_cyc[1], c0 + 7 + LNG);
    check("glitch_long_once", long_cnt[1] - l0, 1);
    set_raw(3'b000);
    wait_cycles(10);

    // simultaneous press
    set_raw(3'b111); c0 = cyc;
    wait_cycles(10);
    for (int ch = 0; ch < N; ch++) check($sformatf("simul_press%0d", ch), press_cyc[ch], c0 + 7);
    set_raw(3'b000);
    wait_cycles(10);

    // reset during ARMING, then during HELD
    set_raw(3'b001);
    wait_cycles(4);
    reset = 1'b1;
    #1;
    check("rst_arming_outputs", int'({btn_level, btn_press, btn_release, btn_long}), 0);
    wait_cycles(2);
    reset = 1'b0; c0 = cyc; p0 = press_cnt[0];
    wait_cycles(10);
    check("rst_arming_repress_edge", press_cyc[0], c0 + 7);
    check("rst_arming_repress_once", press_cnt[0] - p0, 1);
    wait_cycles(3);
    reset = 1'b1;
    #1;
    check("rst_held_outputs", int'({btn_level, btn_press, btn_release, btn_long}), 0);
    wait_cycles(2);
    reset = 1'b0; c0 = cyc;
    wait_cycles(10);
    check("rst_held_repress_edge", press_cyc[0], c0 + 7);
    set_raw(3'b000);
    wait_cycles(10);

    // randomized bouncing, holding and occasional resets
    for (int ch = 0; ch < N; ch++) rem[ch] = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #3;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 499) == 0) reset = 1'b1;
      for (int ch = 0; ch < N; ch++) begin
        if (rem[ch] == 0) begin
          btn_raw[ch] = ~btn_raw[ch];
          rem[ch] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4))
                                                 : int'($urandom_range(5, 40));
        end else begin
          rem[ch]--;
        end
      end
    end
    reset   = 1'b0;
    btn_raw = '0;
    wait_cycles(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
